// File: rtl/mc_control.sv
// Multicycle RISC-V control FSM: sequences datapath enables and decodes the ALU operation.
// Latency: one state per clock, 3 to 5 cycles per instruction; outputs are combinational from state and inputs.
// Backpressure: none; the FSM advances unconditionally and only reset leaves HALT.
module mc_control #(
  parameter logic HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] immSrc,
  output logic       regWrite,
  output logic [2:0] aluControl,
  output logic       halted
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BEQ, HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD, ALU_SUB, ALU_FUNCT
  } aluOp_t;

  state_t state, nextState;
  aluOp_t aluOp;

  // Only funct7 bit 5 distinguishes sub from add; the other bits are don't-care here.
  logic unusedF7;
  assign unusedF7 = ^{f7[6], f7[4:0]};

  // State register; reset forces FETCH from any state, including HALT.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // Next-state and per-state datapath controls; anything not named for a state stays 0.
  always_comb begin
    nextState = state;
    pcWrite   = 1'b0;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    regWrite  = 1'b0;
    halted    = 1'b0;
    aluOp     = ALU_ADD;
    case (state)
      FETCH: begin
        adrSrc    = 1'b0;
        irWrite   = 1'b1;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        pcWrite   = 1'b1;
        nextState = DECODE;
      end
      DECODE: begin
        // Branch target OldPC + imm is computed here and parked in ALUOut.
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_R:         nextState = EXECR;
          OP_I:         nextState = EXECI;
          OP_JAL:       nextState = JAL;
          OP_BEQ:       nextState = BEQ;
          default:      nextState = HALT_ON_ILLEGAL ? HALT : FETCH;
        endcase
      end
      MEMADR: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        // op[5] separates sw (0100011) from lw (0000011).
        nextState = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        resultSrc = 2'b00;
        adrSrc    = 1'b1;
        nextState = MEMWB;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        nextState = FETCH;
      end
      MEMWRITE: begin
        resultSrc = 2'b00;
        adrSrc    = 1'b1;
        memWrite  = 1'b1;
        nextState = FETCH;
      end
      EXECR: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b00;
        aluOp     = ALU_FUNCT;
        nextState = ALUWB;
      end
      EXECI: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        aluOp     = ALU_FUNCT;
        nextState = ALUWB;
      end
      ALUWB: begin
        resultSrc = 2'b00;
        regWrite  = 1'b1;
        nextState = FETCH;
      end
      JAL: begin
        // Link value OldPC + 4 is formed here while the PC takes the target from ALUOut.
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        resultSrc = 2'b00;
        pcWrite   = 1'b1;
        nextState = ALUWB;
      end
      BEQ: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b00;
        aluOp     = ALU_SUB;
        resultSrc = 2'b00;
        pcWrite   = zero;
        nextState = FETCH;
      end
      HALT: begin
        halted    = 1'b1;
        nextState = HALT;
      end
      default: nextState = FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    immSrc = 2'b00;
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  // ALU decoder; sub only for R-type funct3=000 with funct7[5] set (addi never subtracts).
  always_comb begin
    aluControl = 3'b000;
    case (aluOp)
      ALU_ADD: aluControl = 3'b000;
      ALU_SUB: aluControl = 3'b001;
      default: begin
        case (f3)
          3'b000:  aluControl = (op[5] & f7[5]) ? 3'b001 : 3'b000;
          3'b010:  aluControl = 3'b101;
          3'b110:  aluControl = 3'b011;
          3'b111:  aluControl = 3'b010;
          default: aluControl = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: two instances (illegal opcode returns vs. halts) share all inputs.
// Each step advances one clock and compares the full packed output vector of both instances.
// Expected vectors are written out by hand per state from the control table.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       zero;

  logic       pcWrite0, adrSrc0, memWrite0, irWrite0, regWrite0, halted0;
  logic [1:0] resultSrc0, aluSrcA0, aluSrcB0, immSrc0;
  logic [2:0] aluControl0;
  logic       pcWrite1, adrSrc1, memWrite1, irWrite1, regWrite1, halted1;
  logic [1:0] resultSrc1, aluSrcA1, aluSrcB1, immSrc1;
  logic [2:0] aluControl1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_control #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
    .pcWrite(pcWrite0), .adrSrc(adrSrc0), .memWrite(memWrite0), .irWrite(irWrite0),
    .resultSrc(resultSrc0), .aluSrcA(aluSrcA0), .aluSrcB(aluSrcB0), .immSrc(immSrc0),
    .regWrite(regWrite0), .aluControl(aluControl0), .halted(halted0)
  );

  mc_control #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
    .pcWrite(pcWrite1), .adrSrc(adrSrc1), .memWrite(memWrite1), .irWrite(irWrite1),
    .resultSrc(resultSrc1), .aluSrcA(aluSrcA1), .aluSrcB(aluSrcB1), .immSrc(immSrc1),
    .regWrite(regWrite1), .aluControl(aluControl1), .halted(halted1)
  );

  // {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, immSrc, regWrite, aluControl, halted}
  logic [16:0] obs0, obs1;
  assign obs0 = {pcWrite0, adrSrc0, memWrite0, irWrite0, resultSrc0, aluSrcA0, aluSrcB0,
                 immSrc0, regWrite0, aluControl0, halted0};
  assign obs1 = {pcWrite1, adrSrc1, memWrite1, irWrite1, resultSrc1, aluSrcA1, aluSrcB1,
                 immSrc1, regWrite1, aluControl1, halted1};

  function automatic logic [16:0] mk(input logic pw, input logic ad, input logic mw,
                                     input logic iw, input logic [1:0] rs, input logic [1:0] aa,
                                     input logic [1:0] ab, input logic [1:0] im, input logic rw,
                                     input logic [2:0] ac, input logic h);
    return {pw, ad, mw, iw, rs, aa, ab, im, rw, ac, h};
  endfunction

  // Hand-written per-state vectors; im is the immediate format of the current opcode.
  function automatic logic [16:0] sFetch(input logic [1:0] im);
    return mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, im, 0, 3'b000, 0);
  endfunction
  function automatic logic [16:0] sDecode(input logic [1:0] im);
    return mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 0, 3'b000, 0);
  endfunction
  function automatic logic [16:0] sAluWb(input logic [1:0] im);
    return mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 1, 3'b000, 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [16:0] e0, input logic [16:0] e1);
    checks++;
    assert (obs0 === e0) else begin
      errors++;
      $error("FAIL %s (ret): observed %b expected %b", tag, obs0, e0);
    end
    checks++;
    assert (obs1 === e1) else begin
      errors++;
      $error("FAIL %s (halt): observed %b expected %b", tag, obs1, e1);
    end
  endtask

  logic [16:0] haltVec;

  initial begin
    haltVec = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 1);
    reset = 1'b1; op = 7'b0000011; f3 = 3'b000; f7 = 7'b0000000; zero = 1'b0;

    // lw: reset holds FETCH, then FETCH DECODE MEMADR MEMREAD MEMWB
    tick();
    check("reset_fetch", sFetch(2'b00), sFetch(2'b00));
    tick();
    check("reset_hold_fetch", sFetch(2'b00), sFetch(2'b00));
    reset = 1'b0;
    #1;
    check("lw_fetch", sFetch(2'b00), sFetch(2'b00));
    tick(); check("lw_decode", sDecode(2'b00), sDecode(2'b00));
    tick(); check("lw_memadr", mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0),
                               mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0));
    tick(); check("lw_memread", mk(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0),
                                mk(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0));
    tick(); check("lw_memwb", mk(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,3'b000,0),
                              mk(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,3'b000,0));
    tick();

    // sw: FETCH DECODE MEMADR MEMWRITE
    op = 7'b0100011;
    #1;
    check("sw_fetch", sFetch(2'b01), sFetch(2'b01));
    tick(); check("sw_decode", sDecode(2'b01), sDecode(2'b01));
    tick(); check("sw_memadr", mk(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,3'b000,0),
                               mk(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,3'b000,0));
    tick(); check("sw_memwrite", mk(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,0),
                                 mk(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,0));
    tick(); check("sw_back_fetch", sFetch(2'b01), sFetch(2'b01));

    // beq taken, then zero dropped combinationally inside BEQ
    op = 7'b1100011; zero = 1'b1;
    #1;
    check("beq_fetch", sFetch(2'b10), sFetch(2'b10));
    tick(); check("beq_decode", sDecode(2'b10), sDecode(2'b10));
    tick(); check("beq_taken", mk(1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,0),
                               mk(1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,0));
    zero = 1'b0;
    #1;
    check("beq_zero_comb", mk(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,0),
                           mk(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,0));
    tick(); check("beq_back_fetch", sFetch(2'b10), sFetch(2'b10));

    // beq not taken
    tick(); check("beq_nt_decode", sDecode(2'b10), sDecode(2'b10));
    tick(); check("beq_not_taken", mk(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,0),
                                   mk(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,0));
    tick();

    // R-type sub, then other funct3 decodes while sitting in EXECR
    op = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000;
    #1;
    check("r_fetch", sFetch(2'b00), sFetch(2'b00));
    tick(); check("r_decode", sDecode(2'b00), sDecode(2'b00));
    tick(); check("r_sub", mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b001,0),
                           mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b001,0));
    f3 = 3'b111; #1;
    check("r_and", mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b010,0),
                   mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b010,0));
    f3 = 3'b010; #1;
    check("r_slt", mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b101,0),
                   mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b101,0));
    f3 = 3'b110; #1;
    check("r_or", mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b011,0),
                  mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b011,0));
    f3 = 3'b000; f7 = 7'b0000000; #1;
    check("r_add", mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b000,0),
                   mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b000,0));
    tick(); check("r_aluwb", sAluWb(2'b00), sAluWb(2'b00));
    tick();

    // addi with funct7[5] set must still add
    op = 7'b0010011; f3 = 3'b000; f7 = 7'b0100000;
    tick(); check("i_decode", sDecode(2'b00), sDecode(2'b00));
    tick(); check("i_addi", mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0),
                            mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0));
    tick(); check("i_aluwb", sAluWb(2'b00), sAluWb(2'b00));
    tick();

    // jal: immSrc 11 in every state
    op = 7'b1101111; f7 = 7'b0000000;
    #1;
    check("jal_fetch", sFetch(2'b11), sFetch(2'b11));
    tick(); check("jal_decode", sDecode(2'b11), sDecode(2'b11));
    tick(); check("jal_jal", mk(1,0,0,0,2'b00,2'b01,2'b10,2'b11,0,3'b000,0),
                             mk(1,0,0,0,2'b00,2'b01,2'b10,2'b11,0,3'b000,0));
    tick(); check("jal_aluwb", sAluWb(2'b11), sAluWb(2'b11));
    tick();

    // illegal opcode: one instance loops back to FETCH, the other halts until reset
    op = 7'b1111111;
    #1;
    check("ill_fetch", sFetch(2'b00), sFetch(2'b00));
    tick(); check("ill_decode", sDecode(2'b00), sDecode(2'b00));
    tick(); check("ill_after_decode", sFetch(2'b00), haltVec);
    tick(); check("ill_halt_persist1", sDecode(2'b00), haltVec);
    tick(); check("ill_halt_persist2", sFetch(2'b00), haltVec);
    reset = 1'b1;
    tick(); check("ill_reset", sFetch(2'b00), sFetch(2'b00));
    reset = 1'b0;
    #1;
    check("ill_released", sFetch(2'b00), sFetch(2'b00));

    // reset during MEMREAD of a lw: back to FETCH, no regWrite afterwards
    op = 7'b0000011;
    tick(); check("rst_lw_decode", sDecode(2'b00), sDecode(2'b00));
    tick(); tick();
    check("rst_lw_memread", mk(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0),
                            mk(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0));
    reset = 1'b1;
    tick(); check("rst_mid_fetch", sFetch(2'b00), sFetch(2'b00));
    reset = 1'b0;
    #1;
    check("rst_mid_released", sFetch(2'b00), sFetch(2'b00));
    tick(); check("rst_mid_decode", sDecode(2'b00), sDecode(2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
